// File: rtl/bin2bcd.sv
// rtl/bin2bcd.sv - sequential binary-to-BCD converter (shift-and-add-3, one bit per clock)
module bin2bcd #(
    parameter int BIN_W = 7,
    parameter int NDIG  = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [BIN_W-1:0]   bin,
    output logic [4*NDIG-1:0]  bcd,
    output logic               ready,
    output logic               done_tick
);

    localparam int CW = $clog2(BIN_W + 1);
    localparam int BW = 4 * NDIG;

    // Too few digits would silently drop the most significant decimal digit.
    if ((10 ** NDIG) <= (2 ** BIN_W)) begin : g_ndig_check
        $error("bin2bcd: NDIG too small, need 10**NDIG > 2**BIN_W");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_OP,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [BIN_W-1:0]  shift_q, shift_d;
    logic [BW-1:0]     work_q, work_d;
    logic [BW-1:0]     work_adj;
    logic [BW-1:0]     bcd_q, bcd_d;
    logic [CW-1:0]     cnt_q, cnt_d;

    always_comb begin
        work_adj = work_q;
        for (int i = 0; i < NDIG; i++) begin
            if (work_q[4*i +: 4] >= 4'd5) begin
                work_adj[4*i +: 4] = work_q[4*i +: 4] + 4'd3;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        work_d    = work_q;
        cnt_d     = cnt_q;
        bcd_d     = bcd_q;
        ready     = 1'b0;
        done_tick = 1'b0;
        case (state_q)
            S_IDLE: begin
                ready = 1'b1;
                if (start) begin
                    shift_d = bin;
                    work_d  = '0;
                    cnt_d   = CW'(BIN_W);
                    state_d = S_OP;
                end
            end
            S_OP: begin
                // The binary MSB falls into the units digit LSB; the top work bit drops out.
                {work_d, shift_d} = {work_adj, shift_q} << 1;
                cnt_d             = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    bcd_d   = work_d;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                done_tick = 1'b1;
                state_d   = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            shift_q <= '0;
            work_q  <= '0;
            cnt_q   <= '0;
            bcd_q   <= '0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            work_q  <= work_d;
            cnt_q   <= cnt_d;
            bcd_q   <= bcd_d;
        end
    end

    assign bcd = bcd_q;

endmodule

// File: tb/tb_bin2bcd.sv
// tb/tb_bin2bcd.sv - directed self-checking bench for bin2bcd
module tb_bin2bcd;

    localparam int BIN_W = 7;
    localparam int NDIG  = 3;
    localparam int LAT   = BIN_W + 1;
    localparam int BOUND = 40;

    logic              clk;
    logic              rst_n;
    logic              start;
    logic [BIN_W-1:0]  bin;
    logic [11:0]       bcd;
    logic              ready;
    logic              done_tick;

    int checks;
    int errors;

    bin2bcd #(.BIN_W(BIN_W), .NDIG(NDIG)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .bin       (bin),
        .bcd       (bcd),
        .ready     (ready),
        .done_tick (done_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [11:0] dec(input int v);
        dec = {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    // Starts a conversion at a falling edge and returns at the falling edge where done_tick is seen.
    task automatic run_conv(input int v, input bit hold, output int lat, output int rdy_low,
                            output bit got_done);
        @(negedge clk);
        bin      = BIN_W'(v);
        start    = 1'b1;
        lat      = 0;
        rdy_low  = 0;
        got_done = 1'b0;
        while (!got_done && lat < BOUND) begin
            @(negedge clk);
            lat++;
            if (!hold) start = 1'b0;
            if (!ready) rdy_low++;
            if (done_tick) got_done = 1'b1;
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        bin   = '0;
        #1;
        checks++;
        if (ready !== 1'b1 || done_tick !== 1'b0 || bcd !== 12'h000) begin
            errors++;
            $display("FAIL reset: ready=%b done=%b bcd=%h, want 1 0 000", ready, done_tick, bcd);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_zero();
        int lat, rl;
        bit ok;
        run_conv(0, 1'b0, lat, rl, ok);
        checks++;
        if (!ok || lat !== LAT) begin
            errors++;
            $display("FAIL zero_latency: done=%b lat=%0d, want 1 %0d", ok, lat, LAT);
        end
        checks++;
        if (bcd !== 12'h000 || ready !== 1'b0) begin
            errors++;
            $display("FAIL zero_result: bcd=%h ready=%b, want 000 0", bcd, ready);
        end
        checks++;
        if (rl !== LAT) begin
            errors++;
            $display("FAIL zero_ready_low: %0d cycles, want %0d", rl, LAT);
        end
        @(negedge clk);
        checks++;
        if (ready !== 1'b1 || done_tick !== 1'b0) begin
            errors++;
            $display("FAIL zero_back_idle: ready=%b done=%b, want 1 0", ready, done_tick);
        end
    endtask

    task automatic test_directed();
        int          vals [4] = '{99, 127, 5, 10};
        logic [11:0] exp  [4] = '{12'h099, 12'h127, 12'h005, 12'h010};
        int lat, rl;
        bit ok;
        foreach (vals[k]) begin
            run_conv(vals[k], 1'b1, lat, rl, ok);
            checks++;
            if (!ok || bcd !== exp[k]) begin
                errors++;
                $display("FAIL directed_%0d: done=%b bcd=%h, want %h", vals[k], ok, bcd, exp[k]);
            end
        end
    endtask

    task automatic test_sweep();
        int lat, rl;
        bit ok;
        int bad_val, bad_dig;
        logic [11:0] bad_got;
        bad_val = -1;
        bad_dig = -1;
        bad_got = '0;
        for (int v = 0; v < 128; v++) begin
            run_conv(v, 1'b0, lat, rl, ok);
            if ((!ok || bcd !== dec(v)) && bad_val < 0) begin
                bad_val = v;
                bad_got = bcd;
            end
            for (int d = 0; d < NDIG; d++) begin
                if (bcd[4*d +: 4] > 4'd9 && bad_dig < 0) bad_dig = v;
            end
        end
        checks++;
        if (bad_val >= 0) begin
            errors++;
            $display("FAIL sweep: bin=%0d bcd=%h, want %h", bad_val, bad_got, dec(bad_val));
        end
        checks++;
        if (bad_dig >= 0) begin
            errors++;
            $display("FAIL sweep_digit_range: bin=%0d has a digit above 9", bad_dig);
        end
    endtask

    task automatic test_ignore_start();
        int  lat;
        bit  ok, rdy_seen, extra;
        @(negedge clk);
        bin   = 7'd127;
        start = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        lat      = 1;
        ok       = 1'b0;
        rdy_seen = 1'b0;
        while (!ok && lat < BOUND) begin
            if (lat == 3) begin
                bin   = 7'd3;
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            if (ready) rdy_seen = 1'b1;
            @(negedge clk);
            lat++;
            if (done_tick) ok = 1'b1;
        end
        start = 1'b0;
        checks++;
        if (!ok || bcd !== 12'h127) begin
            errors++;
            $display("FAIL ignore_start_result: done=%b bcd=%h, want 127", ok, bcd);
        end
        checks++;
        if (rdy_seen) begin
            errors++;
            $display("FAIL ignore_start_ready: ready=1 during OP, want 0");
        end
        extra = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (done_tick || !ready) extra = 1'b1;
        end
        checks++;
        if (extra) begin
            errors++;
            $display("FAIL ignore_start_extra: extra conversion seen, want none");
        end
    endtask

    task automatic test_back_to_back();
        int lat, rl, gap;
        bit ok;
        run_conv(42, 1'b1, lat, rl, ok);
        start = 1'b1;
        checks++;
        if (!ok || bcd !== 12'h042) begin
            errors++;
            $display("FAIL b2b_first: done=%b bcd=%h, want 042", ok, bcd);
        end
        for (int n = 0; n < 2; n++) begin
            gap = 0;
            do begin
                @(negedge clk);
                gap++;
            end while (!done_tick && gap < BOUND);
            checks++;
            if (gap !== BIN_W + 2 || bcd !== 12'h042) begin
                errors++;
                $display("FAIL b2b_period_%0d: gap=%0d bcd=%h, want %0d 042", n, gap, bcd, BIN_W + 2);
            end
        end
        start = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int lat, rl;
        bit ok, spurious;
        @(negedge clk);
        bin   = 7'd127;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (bcd !== 12'h000 || ready !== 1'b1 || done_tick !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: bcd=%h ready=%b done=%b, want 000 1 0", bcd, ready, done_tick);
        end
        @(negedge clk);
        rst_n    = 1'b1;
        spurious = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (done_tick) spurious = 1'b1;
        end
        checks++;
        if (spurious) begin
            errors++;
            $display("FAIL reset_mid_no_done: done_tick after aborted request");
        end
        run_conv(88, 1'b0, lat, rl, ok);
        checks++;
        if (!ok || bcd !== 12'h088) begin
            errors++;
            $display("FAIL reset_mid_next: done=%b bcd=%h, want 088", ok, bcd);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_zero();
        test_directed();
        test_sweep();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
